eth_loop_addr_swap_pipe: RTL and testbench
==========================================

// Module: eth_loop_addr_swap_pipe
// PURPOSE
// - Parametrised MAC DA/SA swapper in the 10GbE loopback path, between the loop MUX (AXIS in) and layer-2 (AXIS out).
// - Swaps destination and source MAC addresses (bytes 0-5 <-> 6-11) of each frame when swap is enabled.
// - Generic data width with full AXIS back-pressure.
// - Swap enable is frame-atomic and latency is constant, enabled or not.
// PARAMETERS
// - DATA_W   64   AXIS tdata width; legal 64,128,256,512; KEEP_W=DATA_W/8
// - CNT_W    16   width of swapped-frame counter
// - HDR_BEATS (localparam) = (DATA_W==64) ? 2 : 1; beats needed to cover the 12 address bytes
// PORTS
// - piEthCoreClk            in   1        core clock, all logic rising-edge
// - piEthCoreRst_n          in   1        asynchronous active-low reset
// - piSwapEn                in   1        MMIO swap enable, sampled per frame
// - piMUX_Swap_Axis_tdata   in   DATA_W   byte0 = tdata[7:0] = first wire byte
// - piMUX_Swap_Axis_tkeep   in   KEEP_W   contiguous from bit0
// - piMUX_Swap_Axis_tlast   in   1
// - piMUX_Swap_Axis_tvalid  in   1
// - poSWAP_Mux_Axis_tready  out  1
// - piLY2_Swap_Axis_tready  in   1
// - poSWAP_Ly2_Axis_tdata   out  DATA_W
// - poSWAP_Ly2_Axis_tkeep   out  KEEP_W
// - poSWAP_Ly2_Axis_tlast   out  1
// - poSWAP_Ly2_Axis_tvalid  out  1
// - poSwapCnt               out  CNT_W    frames swapped since reset, wraps
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0; pipeline empty; FSM=IDLE; poSwapCnt=0.
// - Datapath: HDR_BEATS-1 hold register H, then output register O.
// - Beat advances H->O when O is empty or O is consumed (tvalid&tready).
// - Input tready = !H_valid | advance. It is combinational from downstream tready, 0 in reset.
// - Latency: input accept of beat k -> beat k on output tvalid after HDR_BEATS cycles, no stall.
// - Full throughput of 1 beat/cycle; no bubbles between back-to-back frames.
// - tdata/tkeep/tlast stable while tvalid & !tready.
// - FSM states:
//   - IDLE: waiting for first beat.
//   - HDR: header incomplete (64-bit only).
//   - BODY: rest of frame.
//   - Any accepted beat with tlast -> IDLE.
// - First accepted beat: latch swp = piSwapEn for the whole frame. Toggling piSwapEn mid-frame has no effect.
// - 64-bit swap: when beat1 is accepted with beat0 in H, rewrite both beats:
//   - beat0 = {b1[31:0], b0[63:48]... } i.e. bytes0-5 <- SA bytes6-11, bytes6-7 <- DA bytes0-1.
//   - beat1[31:0] <- DA bytes2-5; beat1[63:32] unchanged.
// - >=128-bit swap: bytes0-5 <-> bytes6-11 within beat0; remaining bytes unchanged.
// - Runt frame (fewer than 12 valid bytes before tlast): passed unmodified and not counted.
// - 64-bit runt with tlast on beat0: H drains to O without waiting for a new input beat.
// - poSwapCnt increments by 1 when the last beat of a swapped frame is accepted on the output; wraps 2^CNT_W-1 -> 0.
// - tkeep and tlast are never modified; only tdata bytes 0-11 of a frame change.
// - Input tvalid=1 with tkeep=0: treated as a data beat (no special case).
// CONFIGURATION
// - Macro ADDR_SWAP_MCAST_BYPASS_EN.
// - Defined: frames whose DA is group-addressed (byte0 bit0 = 1, includes broadcast) are forwarded unswapped and not counted, even if swp=1.
// - Undefined: every non-runt frame with swp=1 is swapped regardless of DA.
// TESTING
// - T1, DATA_W=64, swap=1, 64B frame:
//   - DA=00:0A:35:00:00:01, SA=00:0A:35:00:00:02
//   - -> out DA/SA exchanged, bytes 12-63 identical, latency 2, poSwapCnt=1.
// - T2, swap=0, same frame -> bit-identical output, latency 2, poSwapCnt=0.
// - T3, swap toggles 1->0 on beat 3 of an 8-beat frame -> frame fully swapped; next frame unswapped.
// - T4, random downstream tready (50%) over 100 back-to-back frames:
//   - -> no beat lost or duplicated; output stable while stalled; poSwapCnt=100.
// - T5, 6-byte runt (tkeep=8'h3F, tlast on beat0), swap=1 -> output unmodified, count unchanged.
// - T6, DATA_W=128, DA=FF:FF:FF:FF:FF:FF:
//   - with ADDR_SWAP_MCAST_BYPASS_EN -> unswapped, count unchanged.
//   - without the macro -> swapped, count +1.
//   - Assert reset mid-frame -> tvalid=0 immediately, next frame processed cleanly.

Source files
------------

// File: rtl/eth_loop_addr_swap_pipe.sv
// eth_loop_addr_swap_pipe: AXIS MAC DA/SA swapper in the 10GbE loopback path (loop MUX -> layer-2).
// Optional build macro ADDR_SWAP_MCAST_BYPASS_EN: group-addressed frames pass unswapped and uncounted.
module eth_loop_addr_swap_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                piEthCoreClk,
    input  logic                piEthCoreRst_n,
    input  logic                piSwapEn,
    input  logic [DATA_W-1:0]   piMUX_Swap_Axis_tdata,
    input  logic [DATA_W/8-1:0] piMUX_Swap_Axis_tkeep,
    input  logic                piMUX_Swap_Axis_tlast,
    input  logic                piMUX_Swap_Axis_tvalid,
    output logic                poSWAP_Mux_Axis_tready,
    input  logic                piLY2_Swap_Axis_tready,
    output logic [DATA_W-1:0]   poSWAP_Ly2_Axis_tdata,
    output logic [DATA_W/8-1:0] poSWAP_Ly2_Axis_tkeep,
    output logic                poSWAP_Ly2_Axis_tlast,
    output logic                poSWAP_Ly2_Axis_tvalid,
    output logic [CNT_W-1:0]    poSwapCnt
);
    localparam int KEEP_W    = DATA_W / 8;
    localparam int HDR_BEATS = (DATA_W == 64) ? 2 : 1;
`ifdef ADDR_SWAP_MCAST_BYPASS_EN
    localparam bit MCAST_BYPASS = 1'b1;
`else
    localparam bit MCAST_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
    state_t stateQ, stateD;

    logic              inAcc, oFree, oPop;
    logic              oValid, oLast, oMark;
    logic [DATA_W-1:0] oData;
    logic [KEEP_W-1:0] oKeep;
    logic [CNT_W-1:0]  cntQ;

    // Next values for the output register, supplied by the width-specific front end.
    logic              oLoad, oLastNext, oMarkNext;
    logic [DATA_W-1:0] oDataNext;
    logic [KEEP_W-1:0] oKeepNext;

    assign oPop  = oValid & piLY2_Swap_Axis_tready;
    assign oFree = ~oValid | piLY2_Swap_Axis_tready;
    assign inAcc = piMUX_Swap_Axis_tvalid & poSWAP_Mux_Axis_tready;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        stateD = stateQ;
        if (inAcc) begin
            if (piMUX_Swap_Axis_tlast)  stateD = IDLE;
            else if (stateQ == IDLE)    stateD = (HDR_BEATS == 2) ? HDR : BODY;
            else                        stateD = BODY;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge piEthCoreClk or negedge piEthCoreRst_n) begin
        if (!piEthCoreRst_n) stateQ <= IDLE;
        else                 stateQ <= stateD;
    end

    generate
        if (HDR_BEATS == 2) begin : gNarrow
            logic              hValid, hLast, hMark, frmSwp, frmSwapped, advance, hdrSwap;
            logic [DATA_W-1:0] hData, beat0New, beat1New;
            logic [KEEP_W-1:0] hKeep;

            // Beat0 waits in H for beat1 so both halves of the address field can be rewritten together.
            assign advance = hValid & oFree & ((stateQ != HDR) | piMUX_Swap_Axis_tvalid);
            // NOTE: tready is forced low while reset is asserted even though it is combinational.
            assign poSWAP_Mux_Axis_tready = piEthCoreRst_n & (~hValid | advance);
            assign hdrSwap = (stateQ == HDR) & inAcc & frmSwp & (&hKeep)
                           & (&piMUX_Swap_Axis_tkeep[3:0]) & ~(MCAST_BYPASS & hData[0]);
            assign beat0New = {hData[15:0], piMUX_Swap_Axis_tdata[31:0], hData[63:48]};
            assign beat1New = {piMUX_Swap_Axis_tdata[63:32], hData[47:16]};

            assign oLoad     = advance;
            assign oDataNext = hdrSwap ? beat0New : hData;
            assign oKeepNext = hKeep;
            assign oLastNext = hLast;
            assign oMarkNext = hMark;

            always_ff @(posedge piEthCoreClk or negedge piEthCoreRst_n) begin
                if (!piEthCoreRst_n) begin
                    hValid     <= 1'b0;
                    hData      <= '0;
                    hKeep      <= '0;
                    hLast      <= 1'b0;
                    hMark      <= 1'b0;
                    frmSwp     <= 1'b0;
                    frmSwapped <= 1'b0;
                end else if (inAcc) begin
                    hValid <= 1'b1;
                    hData  <= hdrSwap ? beat1New : piMUX_Swap_Axis_tdata;
                    hKeep  <= piMUX_Swap_Axis_tkeep;
                    hLast  <= piMUX_Swap_Axis_tlast;
                    hMark  <= piMUX_Swap_Axis_tlast &
                              ((stateQ == HDR) ? hdrSwap : ((stateQ == BODY) & frmSwapped));
                    if (stateQ == IDLE) frmSwp     <= piSwapEn;
                    if (stateQ == HDR)  frmSwapped <= hdrSwap;
                end else if (advance) begin
                    hValid <= 1'b0;
                end
            end
        end else begin : gWide
            logic frmSwapped, hdrSwap;

            assign poSWAP_Mux_Axis_tready = piEthCoreRst_n & oFree;
            assign hdrSwap = (stateQ == IDLE) & inAcc & piSwapEn & (&piMUX_Swap_Axis_tkeep[11:0])
                           & ~(MCAST_BYPASS & piMUX_Swap_Axis_tdata[0]);

            assign oLoad     = inAcc;
            assign oDataNext = hdrSwap ? {piMUX_Swap_Axis_tdata[DATA_W-1:96], piMUX_Swap_Axis_tdata[47:0],
                                          piMUX_Swap_Axis_tdata[95:48]}
                                       : piMUX_Swap_Axis_tdata;
            assign oKeepNext = piMUX_Swap_Axis_tkeep;
            assign oLastNext = piMUX_Swap_Axis_tlast;
            assign oMarkNext = piMUX_Swap_Axis_tlast &
                               ((stateQ == IDLE) ? hdrSwap : ((stateQ == BODY) & frmSwapped));

            always_ff @(posedge piEthCoreClk or negedge piEthCoreRst_n) begin
                if (!piEthCoreRst_n)                  frmSwapped <= 1'b0;
                else if (inAcc && (stateQ == IDLE))   frmSwapped <= hdrSwap;
            end
        end
    endgenerate

    // oMark flags the last beat of a swapped frame; the counter bumps when that beat leaves.
    always_ff @(posedge piEthCoreClk or negedge piEthCoreRst_n) begin
        if (!piEthCoreRst_n) begin
            oValid <= 1'b0;
            oData  <= '0;
            oKeep  <= '0;
            oLast  <= 1'b0;
            oMark  <= 1'b0;
            cntQ   <= '0;
        end else begin
            if (oLoad) begin
                oValid <= 1'b1;
                oData  <= oDataNext;
                oKeep  <= oKeepNext;
                oLast  <= oLastNext;
                oMark  <= oMarkNext;
            end else if (oPop) begin
                oValid <= 1'b0;
            end
            if (oPop && oMark) cntQ <= cntQ + CNT_W'(1);
        end
    end

    assign poSWAP_Ly2_Axis_tdata  = oData;
    assign poSWAP_Ly2_Axis_tkeep  = oKeep;
    assign poSWAP_Ly2_Axis_tlast  = oLast;
    assign poSWAP_Ly2_Axis_tvalid = oValid;
    assign poSwapCnt              = cntQ;

endmodule

// File: tb/tb_eth_loop_addr_swap_pipe.sv
// tb_eth_loop_addr_swap_pipe: directed and random frames through 64-bit and 128-bit swapper instances,
// compared beat by beat against a byte-level frame model.
`timescale 1ns/1ps
module tb_eth_loop_addr_swap_pipe;
`ifdef ADDR_SWAP_MCAST_BYPASS_EN
    localparam bit MCAST_BYPASS = 1'b1;
`else
    localparam bit MCAST_BYPASS = 1'b0;
`endif

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        bit           first;
    } beat_t;

    logic piEthCoreClk = 1'b0;
    logic piEthCoreRst_n = 1'b0;
    logic piSwapEn = 1'b0;

    logic [63:0]  inData64 = '0;   logic [7:0]  inKeep64 = '0;   logic inLast64 = 0, inValid64 = 0;
    logic [127:0] inData128 = '0;  logic [15:0] inKeep128 = '0;  logic inLast128 = 0, inValid128 = 0;
    logic inReady64, inReady128, outValid64, outValid128, outLast64, outLast128;
    logic outReady64 = 1'b0, outReady128 = 1'b0;
    logic [63:0]  outData64;  logic [7:0]  outKeep64;
    logic [127:0] outData128; logic [15:0] outKeep128;
    logic [15:0]  swapCnt64, swapCnt128;

    eth_loop_addr_swap_pipe #(.DATA_W(64), .CNT_W(16)) dut64 (
        .piEthCoreClk(piEthCoreClk), .piEthCoreRst_n(piEthCoreRst_n), .piSwapEn(piSwapEn),
        .piMUX_Swap_Axis_tdata(inData64), .piMUX_Swap_Axis_tkeep(inKeep64),
        .piMUX_Swap_Axis_tlast(inLast64), .piMUX_Swap_Axis_tvalid(inValid64),
        .poSWAP_Mux_Axis_tready(inReady64), .piLY2_Swap_Axis_tready(outReady64),
        .poSWAP_Ly2_Axis_tdata(outData64), .poSWAP_Ly2_Axis_tkeep(outKeep64),
        .poSWAP_Ly2_Axis_tlast(outLast64), .poSWAP_Ly2_Axis_tvalid(outValid64),
        .poSwapCnt(swapCnt64));

    eth_loop_addr_swap_pipe #(.DATA_W(128), .CNT_W(16)) dut128 (
        .piEthCoreClk(piEthCoreClk), .piEthCoreRst_n(piEthCoreRst_n), .piSwapEn(piSwapEn),
        .piMUX_Swap_Axis_tdata(inData128), .piMUX_Swap_Axis_tkeep(inKeep128),
        .piMUX_Swap_Axis_tlast(inLast128), .piMUX_Swap_Axis_tvalid(inValid128),
        .poSWAP_Mux_Axis_tready(inReady128), .piLY2_Swap_Axis_tready(outReady128),
        .poSWAP_Ly2_Axis_tdata(outData128), .poSWAP_Ly2_Axis_tkeep(outKeep128),
        .poSWAP_Ly2_Axis_tlast(outLast128), .poSWAP_Ly2_Axis_tvalid(outValid128),
        .poSwapCnt(swapCnt128));

    always #5 piEthCoreClk = ~piEthCoreClk;

    int errors = 0, checks = 0, cyc = 0, readyPct = 100;
    bit chkLat = 1'b1;
    logic [7:0] frm [256];
    int frmLen;
    beat_t exp64Q[$], exp128Q[$];
    int acc64Q[$], acc128Q[$];
    int expCnt64 = 0, expCnt128 = 0;

    always @(posedge piEthCoreClk) cyc++;

    always @(posedge piEthCoreClk) begin
        #1;
        outReady64  = ($urandom_range(99) < readyPct);
        outReady128 = ($urandom_range(99) < readyPct);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(string tag, logic [159:0] got, logic [159:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic make_frame(int len, bit mcast);
        for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
        frm[0][0] = mcast;
        frmLen = len;
    endtask

    // Reference: exchange the first two 6-byte fields of a long-enough frame, then cut into beats.
    task automatic add_expected(bit swp, bit wide);
        logic [7:0] b [256];
        int bpb, nb, idx;
        bit doSwap;
        beat_t bt;
        bpb = wide ? 16 : 8;
        for (int i = 0; i < frmLen; i++) b[i] = frm[i];
        doSwap = swp && (frmLen >= 12) && !(MCAST_BYPASS && frm[0][0]);
        if (doSwap) for (int i = 0; i < 6; i++) begin b[i] = frm[i+6]; b[i+6] = frm[i]; end
        nb = (frmLen + bpb - 1) / bpb;
        for (int k = 0; k < nb; k++) begin
            bt.data = '0; bt.keep = '0;
            for (int j = 0; j < bpb; j++) begin
                idx = k * bpb + j;
                if (idx < frmLen) begin bt.data[j*8 +: 8] = b[idx]; bt.keep[j] = 1'b1; end
            end
            bt.last = (k == nb - 1);
            bt.first = (k == 0);
            if (wide) exp128Q.push_back(bt); else exp64Q.push_back(bt);
        end
        if (doSwap) begin if (wide) expCnt128++; else expCnt64++; end
    endtask

    task automatic send_frame(bit wide, bit swpFirst, int toggleAt, int validPct);
        int bpb, nb, idx;
        logic [127:0] d;
        logic [15:0] kp;
        bpb = wide ? 16 : 8;
        nb = (frmLen + bpb - 1) / bpb;
        for (int k = 0; k < nb; k++) begin
            d = '0; kp = '0;
            for (int j = 0; j < bpb; j++) begin
                idx = k * bpb + j;
                if (idx < frmLen) begin d[j*8 +: 8] = frm[idx]; kp[j] = 1'b1; end
            end
            while ($urandom_range(99) >= validPct) begin @(posedge piEthCoreClk); #1; end
            piSwapEn = (k < toggleAt) ? swpFirst : !swpFirst;
            if (wide) begin inData128 = d; inKeep128 = kp; inLast128 = (k == nb-1); inValid128 = 1'b1; end
            else begin inData64 = d[63:0]; inKeep64 = kp[7:0]; inLast64 = (k == nb-1); inValid64 = 1'b1; end
            @(negedge piEthCoreClk);
            while (!(wide ? inReady128 : inReady64)) @(negedge piEthCoreClk);
            if (k == 0) begin if (wide) acc128Q.push_back(cyc); else acc64Q.push_back(cyc); end
            @(posedge piEthCoreClk); #1;
            inValid64 = 1'b0; inValid128 = 1'b0;
        end
    endtask

    task automatic frame_go(bit wide, bit swp, int toggleAt, int validPct);
        add_expected(swp, wide);
        send_frame(wide, swp, toggleAt, validPct);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp64Q.size() != 0 || exp128Q.size() != 0) && n < 3000) begin
            @(posedge piEthCoreClk); n++;
        end
        check("drain_complete", (exp64Q.size() + exp128Q.size()), 0);
        @(posedge piEthCoreClk); #1;
    endtask

    // Output monitors: beat order/content, latency of first beats, stability while stalled.
    logic [72:0] p64;  bit stall64 = 0;
    logic [144:0] p128; bit stall128 = 0;
    always @(negedge piEthCoreClk) begin
        beat_t e;
        int a;
        if (!piEthCoreRst_n) stall64 = 0;
        else begin
            if (stall64) check("stable64", {outValid64, outLast64, outKeep64, outData64}, {1'b1, p64});
            if (outValid64 && outReady64) begin
                check("beat_avail64", (exp64Q.size() != 0), 1);
                if (exp64Q.size() != 0) begin
                    e = exp64Q.pop_front();
                    check("beat64", {outLast64, outKeep64, outData64}, {e.last, e.keep[7:0], e.data[63:0]});
                    if (e.first && acc64Q.size() != 0) begin
                        a = acc64Q.pop_front();
                        if (chkLat) check("latency64", cyc - a, 2);
                    end
                end
            end
            stall64 = outValid64 && !outReady64;
            p64 = {outLast64, outKeep64, outData64};
        end
    end

    always @(negedge piEthCoreClk) begin
        beat_t e;
        int a;
        if (!piEthCoreRst_n) stall128 = 0;
        else begin
            if (stall128) check("stable128", {outValid128, outLast128, outKeep128, outData128}, {1'b1, p128});
            if (outValid128 && outReady128) begin
                check("beat_avail128", (exp128Q.size() != 0), 1);
                if (exp128Q.size() != 0) begin
                    e = exp128Q.pop_front();
                    check("beat128", {outLast128, outKeep128, outData128}, {e.last, e.keep, e.data});
                    if (e.first && acc128Q.size() != 0) begin
                        a = acc128Q.pop_front();
                        if (chkLat) check("latency128", cyc - a, 1);
                    end
                end
            end
            stall128 = outValid128 && !outReady128;
            p128 = {outLast128, outKeep128, outData128};
        end
    end

    initial begin
        logic [47:0] da, sa;
        logic [15:0] cntBefore;
        piEthCoreRst_n = 1'b0;
        repeat (3) @(posedge piEthCoreClk);
        #1;
        check("rst_out64", {outValid64, outLast64, outKeep64, outData64, inReady64}, 0);
        check("rst_out128", {outValid128, outLast128, outKeep128, outData128, inReady128}, 0);
        check("rst_cnt", {swapCnt64, swapCnt128}, 0);
        @(negedge piEthCoreClk) piEthCoreRst_n = 1'b1;
        @(posedge piEthCoreClk); #1;

        // T1/T2: fixed addresses, swap on then off
        da = 48'h000A35000001; sa = 48'h000A35000002;
        make_frame(64, 1'b0);
        for (int i = 0; i < 6; i++) begin frm[i] = da[47-8*i -: 8]; frm[i+6] = sa[47-8*i -: 8]; end
        frame_go(1'b0, 1'b1, 99, 100);
        drain();
        check("t1_cnt", swapCnt64, 1);
        frame_go(1'b0, 1'b0, 99, 100);
        drain();
        check("t2_cnt", swapCnt64, 1);

        // T3: enable drops on beat 3, frame stays swapped; next frame unswapped
        make_frame(64, 1'b0);
        frame_go(1'b0, 1'b1, 3, 100);
        make_frame(64, 1'b0);
        frame_go(1'b0, 1'b0, 99, 100);
        drain();
        check("t3_cnt", swapCnt64, expCnt64);

        // T5: 6-byte runt plus a 10-byte runt
        make_frame(6, 1'b0);  frame_go(1'b0, 1'b1, 99, 100);
        make_frame(10, 1'b0); frame_go(1'b0, 1'b1, 99, 100);
        drain();
        check("t5_cnt", swapCnt64, expCnt64);

        // T6: 128-bit broadcast, unicast, runt
        make_frame(64, 1'b1);
        for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
        frame_go(1'b1, 1'b1, 99, 100);
        drain();
        check("t6_bcast_cnt", swapCnt128, MCAST_BYPASS ? 0 : 1);
        make_frame(40, 1'b0); frame_go(1'b1, 1'b1, 99, 100);
        make_frame(8, 1'b0);  frame_go(1'b1, 1'b1, 99, 100);
        drain();
        check("t6_cnt", swapCnt128, expCnt128);

        // T4: 100 back-to-back unicast frames, 50% downstream ready
        chkLat = 1'b0; readyPct = 50;
        cntBefore = swapCnt64;
        for (int f = 0; f < 100; f++) begin
            make_frame($urandom_range(12, 64), 1'b0);
            frame_go(1'b0, 1'b1, 99, 100);
        end
        drain();
        check("t4_cnt_delta", swapCnt64 - cntBefore, 100);

        // Random mix: lengths incl. runts, group DAs, toggling enable, input bubbles
        readyPct = 70;
        for (int f = 0; f < 60; f++) begin
            bit w;
            w = (f % 3 == 0);
            make_frame($urandom_range(1, 48), 1'($urandom_range(1)));
            frame_go(w, 1'($urandom_range(1)), $urandom_range(1, 4), 75);
        end
        drain();
        check("rand_cnt64", swapCnt64, expCnt64);
        check("rand_cnt128", swapCnt128, expCnt128);

        // Reset in the middle of a frame
        readyPct = 100;
        @(posedge piEthCoreClk); #1;
        make_frame(64, 1'b0);
        piSwapEn = 1'b1;
        inData64 = {frm[7], frm[6], frm[5], frm[4], frm[3], frm[2], frm[1], frm[0]};
        inKeep64 = 8'hFF; inLast64 = 1'b0; inValid64 = 1'b1;
        repeat (2) @(posedge piEthCoreClk);
        #1;
        check("midrst_pre_valid", outValid64, 1);
        piEthCoreRst_n = 1'b0;
        #1;
        check("midrst_valid", {outValid64, outValid128, inReady64}, 0);
        check("midrst_cnt", swapCnt64, 0);
        inValid64 = 1'b0;
        exp64Q.delete(); exp128Q.delete(); acc64Q.delete(); acc128Q.delete();
        expCnt64 = 0; expCnt128 = 0;
        @(negedge piEthCoreClk) piEthCoreRst_n = 1'b1;
        @(posedge piEthCoreClk); #1;
        chkLat = 1'b1;
        make_frame(32, 1'b0);
        frame_go(1'b0, 1'b1, 99, 100);
        drain();
        check("post_rst_cnt", swapCnt64, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
